// File: rtl/food_spawn_arbiter_if.sv
// Food refill handshake between the collision block (master) and the spawn arbiter (slave).
// FOOD_SPAWN_AVOID_HEAD_EN adds the snake head positions to the bundle.
interface food_spawn_arbiter_if;
    logic       food_valid_1;
    logic       food_valid_2;
    logic       food_received_1;
    logic       food_received_2;
    logic [7:0] new_food_x1;
    logic [6:0] new_food_y1;
    logic [7:0] new_food_x2;
    logic [6:0] new_food_y2;
    logic       busy;
`ifdef FOOD_SPAWN_AVOID_HEAD_EN
    logic [7:0] snake_1_head_x;
    logic [6:0] snake_1_head_y;
    logic [7:0] snake_2_head_x;
    logic [6:0] snake_2_head_y;
`endif

    modport master (
`ifdef FOOD_SPAWN_AVOID_HEAD_EN
        output snake_1_head_x, snake_1_head_y, snake_2_head_x, snake_2_head_y,
`endif
        output food_valid_1, food_valid_2,
        input  food_received_1, food_received_2,
        input  new_food_x1, new_food_y1, new_food_x2, new_food_y2, busy
    );

    modport slave (
`ifdef FOOD_SPAWN_AVOID_HEAD_EN
        input  snake_1_head_x, snake_1_head_y, snake_2_head_x, snake_2_head_y,
`endif
        input  food_valid_1, food_valid_2,
        output food_received_1, food_received_2,
        output new_food_x1, new_food_y1, new_food_x2, new_food_y2, busy
    );
endinterface

// File: rtl/food_spawn_arbiter.sv
// Round-robin LFSR food refill for two players; FOOD_SPAWN_AVOID_HEAD_EN also rejects snake heads.
// Latency 4 cycles from request to pulse (+2 per retry); requests wait in IDLE while a refill is in flight.
module food_spawn_arbiter #(
    parameter int unsigned X_MIN     = 21,
    parameter int unsigned X_MAX     = 138,
    parameter int unsigned Y_MIN     = 20,
    parameter int unsigned Y_MAX     = 99,
    parameter int unsigned RETRY_MAX = 7,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                 clk,
    input  logic                 resetn,
    food_spawn_arbiter_if.slave  fs
);
    typedef enum logic [1:0] {IDLE, DRAW, CHECK, LOAD} state_t;

    localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam logic [15:0] TAPS = 16'hB400;

    state_t      state_q, state_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic        gnt_q, gnt_d;
    logic        rr_q, rr_d;
    logic [1:0]  served_q, served_d;
    logic [3:0]  retry_q, retry_d;
    logic [7:0]  cand_x_q, cand_x_d;
    logic [6:0]  cand_y_q, cand_y_d;
    logic [7:0]  x1_q, x1_d, x2_q, x2_d;
    logic [6:0]  y1_q, y1_d, y2_q, y2_d;
    logic        rcv1_q, rcv1_d, rcv2_q, rcv2_d;
    logic        busy_q, busy_d;

    logic [1:0]  req;
    logic [7:0]  oth_x;
    logic [6:0]  oth_y;
    logic        cand_ok;

    assign req = {fs.food_valid_2, fs.food_valid_1} & ~served_q;

    // Candidate must land in the playfield and not on the other player's food.
    always_comb begin
        oth_x   = gnt_q ? x1_q : x2_q;
        oth_y   = gnt_q ? y1_q : y2_q;
        cand_ok = (cand_x_q >= 8'(X_MIN)) && (cand_x_q <= 8'(X_MAX)) &&
                  (cand_y_q >= 7'(Y_MIN)) && (cand_y_q <= 7'(Y_MAX)) &&
                  !((cand_x_q == oth_x) && (cand_y_q == oth_y));
`ifdef FOOD_SPAWN_AVOID_HEAD_EN
        if (((cand_x_q == fs.snake_1_head_x) && (cand_y_q == fs.snake_1_head_y)) ||
            ((cand_x_q == fs.snake_2_head_x) && (cand_y_q == fs.snake_2_head_y))) begin
            cand_ok = 1'b0;
        end
`endif
    end

    always_comb begin
        state_d  = state_q;
        lfsr_d   = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : 16'h0000);
        gnt_d    = gnt_q;
        rr_d     = rr_q;
        retry_d  = retry_q;
        cand_x_d = cand_x_q;
        cand_y_d = cand_y_q;
        x1_d     = x1_q;
        y1_d     = y1_q;
        x2_d     = x2_q;
        y2_d     = y2_q;
        rcv1_d   = 1'b0;
        rcv2_d   = 1'b0;
        // A dropped valid re-arms its player; LOAD below overrides for the granted one.
        served_d = served_q & {fs.food_valid_2, fs.food_valid_1};

        case (state_q)
            IDLE: begin
                if (req != 2'b00) begin
                    gnt_d   = (req == 2'b11) ? rr_q : req[1];
                    state_d = DRAW;
                end
            end
            DRAW: begin
                cand_x_d = lfsr_q[7:0];
                cand_y_d = lfsr_q[14:8];
                state_d  = CHECK;
            end
            CHECK: begin
                if (cand_ok) begin
                    state_d = LOAD;
                end else if (retry_q < 4'(RETRY_MAX)) begin
                    retry_d = retry_q + 4'd1;
                    state_d = DRAW;
                end else begin
                    cand_x_d = 8'(X_MIN) + {2'b00, cand_x_q[5:0]};
                    cand_y_d = 7'(Y_MIN) + {1'b0, cand_y_q[5:0]};
                    state_d  = LOAD;
                end
            end
            LOAD: begin
                if (gnt_q) begin
                    x2_d        = cand_x_q;
                    y2_d        = cand_y_q;
                    rcv2_d      = 1'b1;
                    served_d[1] = 1'b1;
                end else begin
                    x1_d        = cand_x_q;
                    y1_d        = cand_y_q;
                    rcv1_d      = 1'b1;
                    served_d[0] = 1'b1;
                end
                rr_d    = ~gnt_q;
                retry_d = 4'd0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            lfsr_q   <= SEED;
            gnt_q    <= 1'b0;
            rr_q     <= 1'b0;
            served_q <= 2'b00;
            retry_q  <= 4'd0;
            cand_x_q <= 8'd0;
            cand_y_q <= 7'd0;
            x1_q     <= 8'd40;
            y1_q     <= 7'd30;
            x2_q     <= 8'd120;
            y2_q     <= 7'd90;
            rcv1_q   <= 1'b0;
            rcv2_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            gnt_q    <= gnt_d;
            rr_q     <= rr_d;
            served_q <= served_d;
            retry_q  <= retry_d;
            cand_x_q <= cand_x_d;
            cand_y_q <= cand_y_d;
            x1_q     <= x1_d;
            y1_q     <= y1_d;
            x2_q     <= x2_d;
            y2_q     <= y2_d;
            rcv1_q   <= rcv1_d;
            rcv2_q   <= rcv2_d;
            busy_q   <= busy_d;
        end
    end

    assign fs.food_received_1 = rcv1_q;
    assign fs.food_received_2 = rcv2_q;
    assign fs.new_food_x1     = x1_q;
    assign fs.new_food_y1     = y1_q;
    assign fs.new_food_x2     = x2_q;
    assign fs.new_food_y2     = y2_q;
    assign fs.busy            = busy_q;
endmodule

// File: tb/tb_food_spawn_arbiter.sv
// Random valid traffic against a transaction-level refill model; directed round-robin and mid-LOAD reset.
module tb_food_spawn_arbiter;
    localparam int unsigned X_MIN     = 21;
    localparam int unsigned X_MAX     = 138;
    localparam int unsigned Y_MIN     = 20;
    localparam int unsigned Y_MAX     = 99;
    localparam int unsigned RETRY_MAX = 7;
    localparam logic [15:0] SEED      = 16'hACE1;
    localparam int          SOAK      = 10000;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    food_spawn_arbiter_if fs_if();

    food_spawn_arbiter #(
        .X_MIN(X_MIN), .X_MAX(X_MAX), .Y_MIN(Y_MIN), .Y_MAX(Y_MAX),
        .RETRY_MAX(RETRY_MAX), .LFSR_SEED(SEED)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .fs     (fs_if)
    );

`ifdef FOOD_SPAWN_AVOID_HEAD_EN
    localparam logic [7:0] H1X = 8'd60;
    localparam logic [6:0] H1Y = 7'd50;
    localparam logic [7:0] H2X = 8'd100;
    localparam logic [6:0] H2Y = 7'd70;
    assign fs_if.snake_1_head_x = H1X;
    assign fs_if.snake_1_head_y = H1Y;
    assign fs_if.snake_2_head_x = H2X;
    assign fs_if.snake_2_head_y = H2Y;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: whole refill outcome is decided at grant time.
    logic [15:0] m_lfsr;
    int          m_cyc;
    bit          m_busy;
    int          m_fin;
    int          m_g;
    logic [7:0]  m_rx;
    logic [6:0]  m_ry;
    logic [7:0]  mx [2];
    logic [6:0]  my [2];
    int          m_rr;
    bit          m_srv [2];
    bit          m_pulse [2];
    bit          m_busy_out;
    bit          v [2];
    bit          seen [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic bit in_field(input logic [7:0] x, input logic [6:0] y);
        return (int'(x) >= int'(X_MIN)) && (int'(x) <= int'(X_MAX)) &&
               (int'(y) >= int'(Y_MIN)) && (int'(y) <= int'(Y_MAX));
    endfunction

    function automatic bit acceptable(input logic [7:0] x, input logic [6:0] y,
                                      input logic [7:0] ox, input logic [6:0] oy);
        bit ok;
        ok = in_field(x, y) && !((x == ox) && (y == oy));
`ifdef FOOD_SPAWN_AVOID_HEAD_EN
        if (((x == H1X) && (y == H1Y)) || ((x == H2X) && (y == H2Y))) ok = 1'b0;
`endif
        return ok;
    endfunction

    task automatic model_reset();
        m_lfsr     = SEED;
        m_cyc      = 0;
        m_busy     = 1'b0;
        m_fin      = 0;
        m_g        = 0;
        mx[0] = 8'd40;  my[0] = 7'd30;
        mx[1] = 8'd120; my[1] = 7'd90;
        m_rr       = 0;
        m_srv[0]   = 1'b0; m_srv[1]   = 1'b0;
        m_pulse[0] = 1'b0; m_pulse[1] = 1'b0;
        m_busy_out = 1'b0;
    endtask

    // Advance the model across one rising edge using this cycle's valids.
    task automatic model_edge();
        bit          r0, r1, done;
        logic [15:0] l;
        logic [7:0]  cx;
        logic [6:0]  cy;
        if (!m_busy) begin
            r0 = v[0] && !m_srv[0];
            r1 = v[1] && !m_srv[1];
            if (r0 || r1) begin
                m_g  = (r0 && r1) ? m_rr : (r1 ? 1 : 0);
                l    = lfsr_next(m_lfsr);
                done = 1'b0;
                for (int k = 0; k <= int'(RETRY_MAX) && !done; k++) begin
                    cx = l[7:0];
                    cy = l[14:8];
                    if (acceptable(cx, cy, mx[1-m_g], my[1-m_g])) begin
                        done = 1'b1; m_rx = cx; m_ry = cy;
                        m_fin = m_cyc + 4 + 2*k;
                    end else if (k == int'(RETRY_MAX)) begin
                        done = 1'b1;
                        m_rx = 8'(X_MIN + int'(cx) % 64);
                        m_ry = 7'(Y_MIN + int'(cy) % 64);
                        m_fin = m_cyc + 4 + 2*k;
                    end
                    l = lfsr_next(lfsr_next(l));
                end
                m_busy = 1'b1;
            end
        end
        m_pulse[0] = 1'b0;
        m_pulse[1] = 1'b0;
        for (int p = 0; p < 2; p++) if (!v[p]) m_srv[p] = 1'b0;
        if (m_busy && (m_fin == m_cyc + 1)) begin
            mx[m_g]      = m_rx;
            my[m_g]      = m_ry;
            m_pulse[m_g] = 1'b1;
            m_srv[m_g]   = 1'b1;
            m_rr         = 1 - m_g;
            m_busy       = 1'b0;
        end
        m_busy_out = m_busy;
        m_lfsr     = lfsr_next(m_lfsr);
        m_cyc++;
    endtask

    task automatic check_outputs();
        chk("x1", 32'(fs_if.new_food_x1), 32'(mx[0]));
        chk("y1", 32'(fs_if.new_food_y1), 32'(my[0]));
        chk("x2", 32'(fs_if.new_food_x2), 32'(mx[1]));
        chk("y2", 32'(fs_if.new_food_y2), 32'(my[1]));
        chk("rcv1", 32'(fs_if.food_received_1), 32'(m_pulse[0]));
        chk("rcv2", 32'(fs_if.food_received_2), 32'(m_pulse[1]));
        chk("busy", 32'(fs_if.busy), 32'(m_busy_out));
        chk("overlap", 32'(fs_if.food_received_1 & fs_if.food_received_2), 32'd0);
        if (fs_if.food_received_1)
            chk("range1", 32'(in_field(fs_if.new_food_x1, fs_if.new_food_y1)), 32'd1);
        if (fs_if.food_received_2)
            chk("range2", 32'(in_field(fs_if.new_food_x2, fs_if.new_food_y2)), 32'd1);
    endtask

    // Called at a negedge: check, drive this cycle's valids, move to the next negedge.
    task automatic step_cycle();
        check_outputs();
        fs_if.food_valid_1 = v[0];
        fs_if.food_valid_2 = v[1];
        model_edge();
        @(negedge clk);
    endtask

    task automatic run_pattern(input bit a, input bit b, input int n, output int first);
        first = -1;
        for (int i = 0; i < n; i++) begin
            v[0] = a;
            v[1] = b;
            step_cycle();
            if (first < 0 && fs_if.food_received_1) first = 0;
            else if (first < 0 && fs_if.food_received_2) first = 1;
        end
    endtask

    initial begin
        int  first;
        bit  found;
        resetn = 1'b0;
        v[0] = 1'b0; v[1] = 1'b0;
        seen[0] = 1'b0; seen[1] = 1'b0;
        fs_if.food_valid_1 = 1'b0;
        fs_if.food_valid_2 = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_outputs();
        resetn = 1'b1;

        // Both requesting from reset: player 1 first.
        run_pattern(1'b1, 1'b1, 50, first);
        chk("rr_first_from_reset", 32'(first), 32'd0);
        run_pattern(1'b0, 1'b0, 5, first);
        // Serve player 1 alone, then both together: player 2 now wins.
        run_pattern(1'b1, 1'b0, 25, first);
        chk("single_p1", 32'(first), 32'd0);
        run_pattern(1'b0, 1'b0, 5, first);
        run_pattern(1'b1, 1'b1, 50, first);
        chk("rr_first_alternate", 32'(first), 32'd1);
        run_pattern(1'b0, 1'b0, 5, first);

        for (int i = 0; i < SOAK; i++) begin
            for (int p = 0; p < 2; p++) begin
                if (!v[p]) begin
                    v[p]    = ($urandom_range(0, 3) == 0);
                    seen[p] = 1'b0;
                end else if (seen[p]) begin
                    v[p] = ($urandom_range(0, 1) == 0);
                end else if ($urandom_range(0, 31) == 0) begin
                    v[p] = 1'b0;
                end
            end
            step_cycle();
            for (int p = 0; p < 2; p++) if (m_pulse[p]) seen[p] = 1'b1;
        end

        // Abort a refill while it sits in LOAD.
        found = 1'b0;
        v[0] = 1'b1; v[1] = 1'b1;
        for (int i = 0; i < 400 && !found; i++) begin
            if (m_busy && (m_fin == m_cyc + 1)) found = 1'b1;
            else step_cycle();
        end
        chk("load_reached", 32'(found), 32'd1);
        resetn = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        check_outputs();
        resetn = 1'b1;
        run_pattern(1'b1, 1'b1, 50, first);
        chk("rr_after_abort", 32'(first), 32'd0);
        run_pattern(1'b0, 1'b0, 5, first);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
